// File: rtl/data_receiver_if.sv
// Pin bundle for data_receiver: FTDI 245 read-side signals plus the downstream
// valid/ready stream and the captured-word counter.
interface data_receiver_if #(
  parameter int CNT_W = 16
);
  logic             rxf_n_in;
  logic [31:0]      data_in;
  logic [3:0]       be_in;
  logic             oe_n_out;
  logic             rd_n_out;
  logic [31:0]      data_out;
  logic [3:0]       be_out;
  logic             valid_out;
  logic             ready_in;
  logic [CNT_W-1:0] word_count_out;

  modport master (
    input  rxf_n_in,
    input  data_in,
    input  be_in,
    input  ready_in,
    output oe_n_out,
    output rd_n_out,
    output data_out,
    output be_out,
    output valid_out,
    output word_count_out
  );

  modport slave (
    output rxf_n_in,
    output data_in,
    output be_in,
    output ready_in,
    input  oe_n_out,
    input  rd_n_out,
    input  data_out,
    input  be_out,
    input  valid_out,
    input  word_count_out
  );
endinterface

// File: rtl/data_receiver.sv
// FTDI 245 synchronous-FIFO read master: bursts words off DATA/BE into a
// first-word-fall-through buffer drained through a valid/ready stream.
module data_receiver #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic            clk_in,
  input  logic            rst_in,
  data_receiver_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] LAUNCH_MAX = CW'(DEPTH - 2);
  localparam logic [CW-1:0] CONT_MAX   = CW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OE   = 2'd1,
    READ = 2'd2,
    TURN = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             oe_n_q, oe_n_d;
  logic             rd_n_q, rd_n_d;
  logic [35:0]      mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [35:0]      head_q, head_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] wc_q, wc_d;

  logic             push_s;
  logic             pop_s;
  logic [35:0]      word_s;

  assign push_s = ~rd_n_q & ~bus.rxf_n_in;
  assign pop_s  = valid_q & bus.ready_in;
  assign word_s = {bus.be_in, bus.data_in};

  // Buffer pointers, occupancy, registered head word and capture counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wc_d     = wc_q;
    head_d   = head_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      wc_d     = wc_q + CNT_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
      wc_d     = wc_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    count_d = count_q + CW'(push_s) - CW'(pop_s);
    valid_d = (count_d != {CW{1'b0}});
    // The incoming word becomes the head when nothing older survives this edge.
    if (count_d == {CW{1'b0}}) begin
      head_d = head_q;
    end else if (push_s && (count_q == CW'(pop_s))) begin
      head_d = word_s;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // Read-strobe sequencer; continuation is judged on post-edge occupancy.
  always_comb begin
    state_d = state_q;
    oe_n_d  = oe_n_q;
    rd_n_d  = rd_n_q;
    case (state_q)
      IDLE: begin
        if (!bus.rxf_n_in && (count_q <= LAUNCH_MAX)) begin
          state_d = OE;
          oe_n_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      OE: begin
        if (!bus.rxf_n_in && (count_d <= CONT_MAX)) begin
          state_d = READ;
          rd_n_d  = 1'b0;
        end else begin
          state_d = TURN;
          oe_n_d  = 1'b1;
        end
      end
      READ: begin
        if (!bus.rxf_n_in && (count_d <= CONT_MAX)) begin
          state_d = READ;
        end else begin
          state_d = TURN;
          oe_n_d  = 1'b1;
          rd_n_d  = 1'b1;
        end
      end
      TURN: begin
        state_d = IDLE;
        oe_n_d  = 1'b1;
        rd_n_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
        oe_n_d  = 1'b1;
        rd_n_d  = 1'b1;
      end
    endcase
  end

  // Control and status registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      oe_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      head_q   <= 36'd0;
      valid_q  <= 1'b0;
      wc_q     <= {CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      oe_n_q   <= oe_n_d;
      rd_n_q   <= rd_n_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
      wc_q     <= wc_d;
    end
  end

  // Buffer storage; a word on the bus at a reset edge is dropped.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 36'd0;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= word_s;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

  assign bus.oe_n_out       = oe_n_q;
  assign bus.rd_n_out       = rd_n_q;
  assign bus.data_out       = head_q[31:0];
  assign bus.be_out         = head_q[35:32];
  assign bus.valid_out      = valid_q;
  assign bus.word_count_out = wc_q;

endmodule

// File: tb/tb_data_receiver.sv
// Self-checking bench for data_receiver: FTDI source model feeding a scoreboard
// queue that is popped and compared as the stream delivers words.
module tb_data_receiver;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_receiver_if #(.CNT_W(CNT_W)) bus ();

  data_receiver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_deliv  = 0;
  int          wc_exp   = 0;
  bit          ftdi_en  = 1'b0;
  logic [35:0] src_q[$];
  logic [35:0] exp_q[$];
  logic [35:0] got_q[$];

  // FTDI source model and scoreboard: sample 2 ns before each rising edge,
  // drive the bus 1 ns after it.
  always begin : ftdi_model
    logic [35:0] w;
    bus.rxf_n_in = !(ftdi_en && (src_q.size() > 0));
    bus.data_in  = (src_q.size() > 0) ? src_q[0][31:0]  : 32'd0;
    bus.be_in    = (src_q.size() > 0) ? src_q[0][35:32] : 4'd0;
    @(negedge clk);
    #3;
    if (!rst && bus.valid_out === 1'b1 && bus.ready_in === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_word: got %h with no word expected", {bus.be_out, bus.data_out});
      end else begin
        w = exp_q.pop_front();
        if ({bus.be_out, bus.data_out} !== w) begin
          $display("FAIL sb_word: got %h expected %h", {bus.be_out, bus.data_out}, w);
        end else begin
          n_pass++;
        end
      end
      got_q.push_back({bus.be_out, bus.data_out});
      n_deliv++;
    end
    if (bus.rd_n_out === 1'b0 && bus.rxf_n_in === 1'b0 && src_q.size() > 0) begin
      w = src_q.pop_front();
      if (!rst) exp_q.push_back(w);
    end
    @(posedge clk);
    #1;
  end

  task automatic wait_drain(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge clk);
      if (src_q.size() == 0 && exp_q.size() == 0 && bus.valid_out === 1'b0 &&
          bus.oe_n_out === 1'b1 && bus.rd_n_out === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) src_q.push_back({4'hF, 32'hDEAD_0000 + 32'(i)});
    ftdi_en = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.oe_n_out !== 1'b1) $display("FAIL rst_oe_n: got %b expected 1", bus.oe_n_out);
      else n_pass++;
      n_checks++;
      if (bus.rd_n_out !== 1'b1) $display("FAIL rst_rd_n: got %b expected 1", bus.rd_n_out);
      else n_pass++;
      n_checks++;
      if (bus.valid_out !== 1'b0) $display("FAIL rst_valid: got %b expected 0", bus.valid_out);
      else n_pass++;
      n_checks++;
      if (bus.word_count_out !== {CNT_W{1'b0}})
        $display("FAIL rst_count: got %0d expected 0", bus.word_count_out);
      else n_pass++;
    end
    ftdi_en = 1'b0;
    src_q.delete();
    @(negedge clk);
    rst = 1'b0;
    wc_exp = 0;
  endtask

  task automatic test_single_burst();
    logic oe_l[40], rd_l[40], rxf_l[40], v_l[40];
    int i_oe, i_rd, i_hi, caps, d0, errs;
    bit ok;
    i_oe = -1; i_rd = -1; i_hi = -1; caps = 0; errs = 0;
    bus.ready_in = 1'b1;
    d0 = n_deliv;
    for (int i = 1; i <= 5; i++) src_q.push_back({4'hF, 32'(i)});
    ftdi_en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      oe_l[c] = bus.oe_n_out; rd_l[c] = bus.rd_n_out;
      rxf_l[c] = bus.rxf_n_in; v_l[c] = bus.valid_out;
    end
    for (int c = 0; c < 40; c++) begin
      if (i_oe < 0 && oe_l[c] === 1'b0) i_oe = c;
      if (i_rd < 0 && rd_l[c] === 1'b0) i_rd = c;
      if (rd_l[c] === 1'b0 && rxf_l[c] === 1'b0) caps++;
    end
    if (i_rd >= 0)
      for (int c = i_rd; c < 40; c++) if (i_hi < 0 && rxf_l[c] === 1'b1) i_hi = c;
    n_checks++;
    if (i_oe < 0 || i_rd != i_oe + 1) $display("FAIL oe_lead: got rd index %0d expected %0d", i_rd, i_oe + 1);
    else n_pass++;
    n_checks++;
    if (i_rd < 0 || i_rd + 1 >= 40 || v_l[i_rd] !== 1'b0 || v_l[i_rd + 1] !== 1'b1)
      $display("FAIL first_valid: got valid rising not one clock after rd_n fell (rd index %0d)", i_rd);
    else n_pass++;
    n_checks++;
    if (caps != 5) $display("FAIL burst_caps: got %0d expected 5", caps);
    else n_pass++;
    n_checks++;
    if (i_hi < 0 || i_hi + 1 >= 40 || oe_l[i_hi + 1] !== 1'b1 || rd_l[i_hi + 1] !== 1'b1)
      $display("FAIL burst_end: got strobes not high the edge after rxf_n rose (index %0d)", i_hi);
    else n_pass++;
    ftdi_en = 1'b0;
    wait_drain(50, ok);
    n_checks++;
    if (!ok) $display("FAIL burst_drain: got timeout expected drained");
    else n_pass++;
    n_checks++;
    if (n_deliv - d0 != 5) $display("FAIL burst_delivered: got %0d expected 5", n_deliv - d0);
    else n_pass++;
    for (int k = 0; k < 5 && d0 + k < got_q.size(); k++)
      if (got_q[d0 + k] !== {4'hF, 32'(k + 1)}) errs++;
    n_checks++;
    if (errs != 0) $display("FAIL burst_order: got %0d out-of-order words expected 0", errs);
    else n_pass++;
    wc_exp += 5;
    n_checks++;
    if (bus.word_count_out !== wc_exp[CNT_W-1:0])
      $display("FAIL burst_count: got %0d expected %0d", bus.word_count_out, wc_exp);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic oe_l[4];
    bit found, relaunched, ok;
    logic rd_full, oe_full;
    int d0;
    found = 1'b0; relaunched = 1'b0; rd_full = 1'b0; oe_full = 1'b0;
    bus.ready_in = 1'b0;
    d0 = n_deliv;
    for (int i = 0; i < 12; i++) src_q.push_back({4'hF, 32'h100 + 32'(i)});
    ftdi_en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (exp_q.size() >= DEPTH) begin
        found = 1'b1; rd_full = bus.rd_n_out; oe_full = bus.oe_n_out;
        break;
      end
    end
    n_checks++;
    if (!found || rd_full !== 1'b1 || oe_full !== 1'b1)
      $display("FAIL stop_at_full: got rd_n=%b oe_n=%b expected both 1 at 8 words", rd_full, oe_full);
    else n_pass++;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.oe_n_out === 1'b0) relaunched = 1'b1;
    end
    n_checks++;
    if (exp_q.size() != DEPTH) $display("FAIL no_overflow: got %0d words expected 8", exp_q.size());
    else n_pass++;
    n_checks++;
    if (relaunched) $display("FAIL hold_idle: got oe_n low while full expected high");
    else n_pass++;
    n_checks++;
    if (bus.valid_out !== 1'b1 || bus.data_out !== 32'h100)
      $display("FAIL head_hold: got valid=%b data=%h expected 1/00000100", bus.valid_out, bus.data_out);
    else n_pass++;
    bus.ready_in = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      oe_l[c] = bus.oe_n_out;
    end
    n_checks++;
    if (oe_l[1] !== 1'b1 || oe_l[2] !== 1'b0)
      $display("FAIL relaunch_at_6: got oe_n %b%b expected 10", oe_l[1], oe_l[2]);
    else n_pass++;
    wait_drain(100, ok);
    ftdi_en = 1'b0;
    n_checks++;
    if (!ok) $display("FAIL bp_drain: got timeout expected drained");
    else n_pass++;
    n_checks++;
    if (n_deliv - d0 != 12) $display("FAIL bp_delivered: got %0d expected 12", n_deliv - d0);
    else n_pass++;
    wc_exp += 12;
    n_checks++;
    if (bus.word_count_out !== wc_exp[CNT_W-1:0])
      $display("FAIL bp_count: got %0d expected %0d", bus.word_count_out, wc_exp);
    else n_pass++;
  endtask

  task automatic test_pushpop_full();
    bit filled, ok;
    int d0, errs;
    filled = 1'b0; errs = 0;
    bus.ready_in = 1'b0;
    d0 = n_deliv;
    for (int i = 0; i < 8; i++) src_q.push_back({4'hF, 32'h200 + 32'(i)});
    ftdi_en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (exp_q.size() >= DEPTH) begin filled = 1'b1; break; end
    end
    n_checks++;
    if (!filled) $display("FAIL pp_fill: got %0d words expected 8", exp_q.size());
    else n_pass++;
    for (int i = 8; i < 18; i++) src_q.push_back({4'hF, 32'h200 + 32'(i)});
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      bus.ready_in = ~bus.ready_in;
      if (src_q.size() == 0 && exp_q.size() == 0) break;
    end
    bus.ready_in = 1'b1;
    wait_drain(100, ok);
    ftdi_en = 1'b0;
    n_checks++;
    if (!ok) $display("FAIL pp_drain: got timeout expected drained");
    else n_pass++;
    n_checks++;
    if (n_deliv - d0 != 18) $display("FAIL pp_delivered: got %0d expected 18", n_deliv - d0);
    else n_pass++;
    for (int k = 0; k < 18 && d0 + k < got_q.size(); k++)
      if (got_q[d0 + k][31:0] !== 32'h200 + 32'(k)) errs++;
    n_checks++;
    if (errs != 0) $display("FAIL pp_sequence: got %0d bad words expected 0", errs);
    else n_pass++;
    wc_exp += 18;
    n_checks++;
    if (bus.word_count_out !== wc_exp[CNT_W-1:0])
      $display("FAIL pp_count: got %0d expected %0d", bus.word_count_out, wc_exp);
    else n_pass++;
  endtask

  task automatic test_partial_be();
    logic [3:0] be_exp[3];
    bit ok;
    int d0;
    be_exp[0] = 4'h3; be_exp[1] = 4'h1; be_exp[2] = 4'h0;
    bus.ready_in = 1'b1;
    d0 = n_deliv;
    for (int i = 0; i < 3; i++) src_q.push_back({be_exp[i], 32'hBE00 + 32'(i)});
    ftdi_en = 1'b1;
    wait_drain(60, ok);
    ftdi_en = 1'b0;
    n_checks++;
    if (!ok || n_deliv - d0 != 3) $display("FAIL be_delivered: got %0d words expected 3", n_deliv - d0);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (d0 + k >= got_q.size()) $display("FAIL be_value: got no word %0d expected be %h", k, be_exp[k]);
      else if (got_q[d0 + k][35:32] !== be_exp[k])
        $display("FAIL be_value: got %h expected %h", got_q[d0 + k][35:32], be_exp[k]);
      else n_pass++;
    end
    wc_exp += 3;
    n_checks++;
    if (bus.word_count_out !== wc_exp[CNT_W-1:0])
      $display("FAIL be_count: got %0d expected %0d", bus.word_count_out, wc_exp);
    else n_pass++;
  endtask

  task automatic test_reset_midburst();
    bit reached, ok;
    int d0, errs;
    reached = 1'b0; errs = 0;
    bus.ready_in = 1'b0;
    for (int i = 0; i < 6; i++) src_q.push_back({4'hF, 32'h300 + 32'(i)});
    ftdi_en = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (exp_q.size() >= 2) begin reached = 1'b1; break; end
    end
    n_checks++;
    if (!reached) $display("FAIL mid_start: got %0d captures expected 2", exp_q.size());
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.oe_n_out !== 1'b1 || bus.rd_n_out !== 1'b1)
      $display("FAIL mid_strobes: got oe_n=%b rd_n=%b expected 1/1", bus.oe_n_out, bus.rd_n_out);
    else n_pass++;
    n_checks++;
    if (bus.valid_out !== 1'b0) $display("FAIL mid_valid: got %b expected 0", bus.valid_out);
    else n_pass++;
    n_checks++;
    if (bus.word_count_out !== {CNT_W{1'b0}})
      $display("FAIL mid_count: got %0d expected 0", bus.word_count_out);
    else n_pass++;
    ftdi_en = 1'b0;
    src_q.delete();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    wc_exp = 0;
    bus.ready_in = 1'b1;
    d0 = n_deliv;
    for (int i = 0; i < 3; i++) src_q.push_back({4'hF, 32'h400 + 32'(i)});
    ftdi_en = 1'b1;
    wait_drain(60, ok);
    ftdi_en = 1'b0;
    n_checks++;
    if (!ok || n_deliv - d0 != 3) $display("FAIL mid_fresh: got %0d words expected 3", n_deliv - d0);
    else n_pass++;
    for (int k = 0; k < 3 && d0 + k < got_q.size(); k++)
      if (got_q[d0 + k][31:0] !== 32'h400 + 32'(k)) errs++;
    n_checks++;
    if (errs != 0) $display("FAIL mid_fresh_data: got %0d stale words expected 0", errs);
    else n_pass++;
    wc_exp += 3;
    n_checks++;
    if (bus.word_count_out !== wc_exp[CNT_W-1:0])
      $display("FAIL mid_fresh_count: got %0d expected %0d", bus.word_count_out, wc_exp);
    else n_pass++;
  endtask

  initial begin
    bus.ready_in = 1'b0;
    test_reset();
    test_single_burst();
    test_backpressure();
    test_pushpop_full();
    test_partial_be();
    test_reset_midburst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
